ahb_slave_if: RTL and testbench



---
 rtl/ahb_slave_if.sv | 164 ++++++++++++++++
 tb/tb_ahb_slave_if.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ahb_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_if
// AHB-facing front end of the AHB-to-APB bridge. It qualifies each AHB
// transfer, decodes the target APB slot from the address, pipelines
// address/write-data/direction into two register stages for the APB
// controller, and produces the two-cycle AHB ERROR response for transfers
// that fall outside the bridge window. Read data passes straight through.
//
// Ports:
//   Hclk, Hreset        clock, synchronous active-high reset
//   Htrans, Hwrite      AHB transfer type and direction
//   Hreadyin            bus-level HREADY; pipeline advances only when 1
//   Haddr, Hwdata       AHB address and write data
//   Prdata              read data from the APB side
//   valid               qualified in-range transfer this cycle (comb)
//   tempselx            one-hot slot decode of Haddr (comb)
//   Haddr1/2, Hwdata1/2 address / write data, one and two stages delayed
//   Hwritereg/1         direction, one and two stages delayed
//   Hresp               00 OKAY, 01 ERROR (registered)
//   Hready_err          low only in the first ERROR cycle (registered)
//   Hrdata              combinational copy of Prdata
// ---------------------------------------------------------------------------
module ahb_slave_if #(
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int          SLOT_BITS = 26
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic        valid,
  output logic [2:0]  tempselx,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [31:0] Hwdata2,
  output logic        Hwritereg,
  output logic        Hwritereg1,
  output logic [1:0]  Hresp,
  output logic        Hready_err,
  output logic [31:0] Hrdata
);

  typedef enum logic [1:0] {
    ST_OKAY = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } state_t;

  // Window end computed in 33 bits so a window touching the top of the
  // address space cannot wrap.
  localparam logic [32:0] WIN_END = {1'b0, BASE} + (33'd3 << SLOT_BITS);

  state_t      state_r, state_s;
  logic [1:0]  hresp_r, hresp_s;
  logic        hready_err_r, hready_err_s;
  logic        in_range_s;
  logic        transfer_s;
  logic [31:0] offset_s;
  logic [1:0]  slot_s;

  assign in_range_s = ({1'b0, Haddr} >= {1'b0, BASE}) && ({1'b0, Haddr} < WIN_END);
  assign transfer_s = Hreadyin && Htrans[1];
  assign offset_s   = Haddr - BASE;
  assign slot_s     = offset_s[SLOT_BITS+1:SLOT_BITS];

  assign valid      = transfer_s && in_range_s && (state_r != ST_ERR1);
  assign Hrdata     = Prdata;
  assign Hresp      = hresp_r;
  assign Hready_err = hready_err_r;

  // One-hot slot decode; anything outside the window selects nothing.
  always_comb begin
    tempselx = 3'b000;
    if (in_range_s) begin
      case (slot_s)
        2'd0:    tempselx = 3'b001;
        2'd1:    tempselx = 3'b010;
        2'd2:    tempselx = 3'b100;
        default: tempselx = 3'b000;
      endcase
    end else begin
      tempselx = 3'b000;
    end
  end

  // Error FSM next state; response outputs are derived from the next state
  // so they can be registered alongside it.
  always_comb begin
    state_s      = state_r;
    hresp_s      = 2'b00;
    hready_err_s = 1'b1;
    case (state_r)
      ST_OKAY: begin
        if (transfer_s && !in_range_s) begin
          state_s = ST_ERR1;
        end else begin
          state_s = ST_OKAY;
        end
      end
      ST_ERR1: state_s = ST_ERR2;
      ST_ERR2: begin
        if (transfer_s && !in_range_s) begin
          state_s = ST_ERR1;
        end else begin
          state_s = ST_OKAY;
        end
      end
      default: state_s = ST_OKAY;
    endcase
    case (state_s)
      ST_ERR1: begin
        hresp_s      = 2'b01;
        hready_err_s = 1'b0;
      end
      ST_ERR2: begin
        hresp_s      = 2'b01;
        hready_err_s = 1'b1;
      end
      default: begin
        hresp_s      = 2'b00;
        hready_err_s = 1'b1;
      end
    endcase
  end

  // Error FSM state and registered response outputs.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_r      <= ST_OKAY;
      hresp_r      <= 2'b00;
      hready_err_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      hresp_r      <= hresp_s;
      hready_err_r <= hready_err_s;
    end
  end

  // Two-stage address/data/direction pipeline; advances on every
  // Hreadyin-high cycle whether or not the transfer was valid.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      Haddr1     <= 32'h0000_0000;
      Haddr2     <= 32'h0000_0000;
      Hwdata1    <= 32'h0000_0000;
      Hwdata2    <= 32'h0000_0000;
      Hwritereg  <= 1'b0;
      Hwritereg1 <= 1'b0;
    end else if (Hreadyin) begin
      Haddr1     <= Haddr;
      Haddr2     <= Haddr1;
      Hwdata1    <= Hwdata;
      Hwdata2    <= Hwdata1;
      Hwritereg  <= Hwrite;
      Hwritereg1 <= Hwritereg;
    end
  end

endmodule

// File: tb/tb_ahb_slave_if.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_if
// Table-driven bench for ahb_slave_if. Each table row gives the AHB inputs,
// the expected combinational valid/tempselx, and the expected Hresp /
// Hready_err after the clock edge. Pipeline contents are tracked by a queue
// scoreboard: every advancing cycle pushes the driven beat, and the two
// newest entries are the expected stage-1 and stage-2 registers.
// ---------------------------------------------------------------------------
module tb_ahb_slave_if;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic        Hreadyin;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
  logic        Hwritereg, Hwritereg1, Hready_err;
  logic [1:0]  Hresp;

  ahb_slave_if dut (
    .Hclk(Hclk), .Hreset(Hreset), .Htrans(Htrans), .Hwrite(Hwrite),
    .Hreadyin(Hreadyin), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .valid(valid), .tempselx(tempselx), .Haddr1(Haddr1), .Haddr2(Haddr2),
    .Hwdata1(Hwdata1), .Hwdata2(Hwdata2), .Hwritereg(Hwritereg),
    .Hwritereg1(Hwritereg1), .Hresp(Hresp), .Hready_err(Hready_err),
    .Hrdata(Hrdata)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    logic [1:0]  htrans;
    logic        hwrite;
    logic        hreadyin;
    logic [31:0] haddr;
    logic        exp_valid;
    logic [2:0]  exp_sel;
    logic [1:0]  exp_hresp;
    logic        exp_rdy;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
  } beat_t;

  vec_t  vecs [21];
  beat_t pq [$];
  int    pass_cnt = 0;
  int    tot_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    beat_t z;
    z.addr = 32'h0; z.data = 32'h0; z.wr = 1'b0;
    pq.delete();
    pq.push_back(z);
    pq.push_back(z);
  endtask

  // One cycle: drive, check comb outputs, clock, check registered outputs.
  task automatic step(input string name, input logic rst, input logic [1:0] tr,
                      input logic wr, input logic rdy, input logic [31:0] addr,
                      input logic [31:0] data, input logic chk_comb,
                      input logic ev, input logic [2:0] es,
                      input logic [1:0] eh, input logic er);
    beat_t b;
    logic [31:0] pr;
    pr = $urandom;
    Hreset = rst; Htrans = tr; Hwrite = wr; Hreadyin = rdy;
    Haddr = addr; Hwdata = data; Prdata = pr;
    #1;
    chk({name, ".hrdata"}, Hrdata, pr);
    if (chk_comb) begin
      chk({name, ".valid"}, {31'b0, valid}, {31'b0, ev});
      chk({name, ".tempselx"}, {29'b0, tempselx}, {29'b0, es});
    end
    @(posedge Hclk);
    #1;
    if (rst) begin
      model_reset();
    end else if (rdy) begin
      b.addr = addr; b.data = data; b.wr = wr;
      pq.push_front(b);
      void'(pq.pop_back());
    end
    chk({name, ".hresp"}, {30'b0, Hresp}, {30'b0, eh});
    chk({name, ".hready_err"}, {31'b0, Hready_err}, {31'b0, er});
    chk({name, ".haddr1"}, Haddr1, pq[0].addr);
    chk({name, ".haddr2"}, Haddr2, pq[1].addr);
    chk({name, ".hwdata1"}, Hwdata1, pq[0].data);
    chk({name, ".hwdata2"}, Hwdata2, pq[1].data);
    chk({name, ".hwritereg"}, {31'b0, Hwritereg}, {31'b0, pq[0].wr});
    chk({name, ".hwritereg1"}, {31'b0, Hwritereg1}, {31'b0, pq[1].wr});
  endtask

  initial begin
    //           htrans hwr  rdy   haddr           valid sel     hresp rdy_err
    vecs[0]  = '{2'b10, 1'b1, 1'b1, 32'h8000_0010, 1'b1, 3'b001, 2'b00, 1'b1};
    vecs[1]  = '{2'b00, 1'b0, 1'b1, 32'h8400_0000, 1'b0, 3'b010, 2'b00, 1'b1};
    vecs[2]  = '{2'b11, 1'b0, 1'b1, 32'h83FF_FFFC, 1'b1, 3'b001, 2'b00, 1'b1};
    vecs[3]  = '{2'b10, 1'b1, 1'b1, 32'h8400_0000, 1'b1, 3'b010, 2'b00, 1'b1};
    vecs[4]  = '{2'b10, 1'b0, 1'b1, 32'h8BFF_FFFC, 1'b1, 3'b100, 2'b00, 1'b1};
    vecs[5]  = '{2'b10, 1'b1, 1'b1, 32'h8C00_0000, 1'b0, 3'b000, 2'b01, 1'b0};
    vecs[6]  = '{2'b10, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 3'b001, 2'b01, 1'b1};
    vecs[7]  = '{2'b00, 1'b0, 1'b1, 32'h9000_0000, 1'b0, 3'b000, 2'b00, 1'b1};
    vecs[8]  = '{2'b10, 1'b1, 1'b1, 32'h9000_0000, 1'b0, 3'b000, 2'b01, 1'b0};
    vecs[9]  = '{2'b00, 1'b0, 1'b1, 32'h9000_0000, 1'b0, 3'b000, 2'b01, 1'b1};
    vecs[10] = '{2'b10, 1'b0, 1'b1, 32'h9000_0000, 1'b0, 3'b000, 2'b01, 1'b0};
    vecs[11] = '{2'b00, 1'b0, 1'b1, 32'h9000_0004, 1'b0, 3'b000, 2'b01, 1'b1};
    vecs[12] = '{2'b10, 1'b1, 1'b1, 32'h8000_1000, 1'b1, 3'b001, 2'b00, 1'b1};
    vecs[13] = '{2'b01, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 3'b001, 2'b00, 1'b1};
    vecs[14] = '{2'b10, 1'b1, 1'b0, 32'h8000_0004, 1'b0, 3'b001, 2'b00, 1'b1};
    vecs[15] = '{2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 3'b000, 2'b00, 1'b1};
    vecs[16] = '{2'b11, 1'b1, 1'b0, 32'h8800_0000, 1'b0, 3'b100, 2'b00, 1'b1};
    vecs[17] = '{2'b10, 1'b0, 1'b1, 32'h8800_0004, 1'b1, 3'b100, 2'b00, 1'b1};
    vecs[18] = '{2'b10, 1'b1, 1'b1, 32'h7FFF_FFFC, 1'b0, 3'b000, 2'b01, 1'b0};
    vecs[19] = '{2'b00, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 3'b001, 2'b01, 1'b1};
    vecs[20] = '{2'b00, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 3'b001, 2'b00, 1'b1};

    // Reset with garbage inputs on the bus.
    #2;
    model_reset();
    step("reset", 1'b1, 2'b11, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D,
         1'b0, 1'b0, 3'b000, 2'b00, 1'b1);

    for (int i = 0; i < 21; i++) begin
      step($sformatf("vec%0d", i), 1'b0, vecs[i].htrans, vecs[i].hwrite,
           vecs[i].hreadyin, vecs[i].haddr, 32'hA5A5_0001 + i, 1'b1,
           vecs[i].exp_valid, vecs[i].exp_sel, vecs[i].exp_hresp, vecs[i].exp_rdy);
    end

    // Reset taking priority while the FSM sits in ERR1.
    step("bad_pre_rst", 1'b0, 2'b10, 1'b1, 1'b1, 32'h9000_0000, 32'h1111_1111,
         1'b1, 1'b0, 3'b000, 2'b01, 1'b0);
    step("rst_in_err1", 1'b1, 2'b10, 1'b1, 1'b1, 32'h9000_0000, 32'h2222_2222,
         1'b0, 1'b0, 3'b000, 2'b00, 1'b1);
    step("post_rst_ok", 1'b0, 2'b10, 1'b0, 1'b1, 32'h8400_0100, 32'h3333_3333,
         1'b1, 1'b1, 3'b010, 2'b00, 1'b1);
    step("post_rst_idle", 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_0000, 32'h4444_4444,
         1'b1, 1'b0, 3'b000, 2'b00, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
